// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and sizing helper
// for the multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    OFF   = 2'd2
  } state_t;

  function automatic int addr_w(input int m);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with zero-reg,
// write-first bypass and clear-pointer masking.
module regfile_rd_port #(
  parameter int N        = 64,
  parameter int A        = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         kill,
  input  logic         ren,
  input  logic [A-1:0] addr,
  input  logic [N-1:0] rdata,
  input  logic         wacc,
  input  logic [A-1:0] waddr,
  input  logic [N-1:0] vin,
  input  logic         clearing,
  input  logic [A-1:0] clr_ptr,
  output logic [N-1:0] vout
);

  logic [N-1:0] rd_val;

  always_comb begin
    rd_val = rdata;
    if ((ZERO_REG != 0) && (addr == '0))
      rd_val = '0;
    else if (wacc && (waddr == addr))
      rd_val = vin;
    else if (clearing && (addr == clr_ptr))
      rd_val = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      vout <= '0;
    else if (kill)
      vout <= '0;
    else if (ren)
      vout <= rd_val;
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: one write port, NR registered read ports,
// sequential clear engine with power-down recovery.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int N        = 64,
  parameter int M        = 32,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NR*addr_w(M)-1:0]  ReadAddr,
  input  logic [NR-1:0]            REn,
  output logic [NR*N-1:0]          Vout,
  input  logic [addr_w(M)-1:0]     WriteAddr,
  input  logic [N-1:0]             Vin,
  input  logic                     WEn,
  input  logic                     Clr,
  input  logic                     Pwr_off,
  output logic                     Busy
);

  localparam int A = addr_w(M);

  state_t       state;
  logic [A-1:0] clr_ptr;
  logic [N-1:0] regs [M];

  logic idle;
  logic clearing;
  logic kill;
  logic wacc;

  assign idle     = (state == IDLE);
  assign clearing = (state == CLEAR);
  // Contents are considered lost as soon as Pwr_off is seen.
  assign kill     = Pwr_off || (state == OFF);
  assign wacc     = idle && !Pwr_off && WEn &&
                    !((ZERO_REG != 0) && (WriteAddr == '0));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < M; i++)
        regs[i] <= '0;
    end else if (!Pwr_off) begin
      if (clearing)
        regs[clr_ptr] <= '0;
      else if (wacc)
        regs[WriteAddr] <= Vin;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      clr_ptr <= '0;
      Busy    <= 1'b0;
    end else if (Pwr_off) begin
      state <= OFF;
      Busy  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (Clr) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            Busy    <= 1'b1;
          end
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + A'(1);
          if (clr_ptr == A'(M - 1)) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        OFF: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          Busy    <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [A-1:0] ra;
    assign ra = ReadAddr[k*A +: A];

    regfile_rd_port #(
      .N        (N),
      .A        (A),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .Clk      (Clk),
      .Rst      (Rst),
      .kill     (kill),
      .ren      (REn[k]),
      .addr     (ra),
      .rdata    (regs[ra]),
      .wacc     (wacc),
      .waddr    (WriteAddr),
      .vin      (Vin),
      .clearing (clearing),
      .clr_ptr  (clr_ptr),
      .vout     (Vout[k*N +: N])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench with a behavioural model,
// directed scenarios then randomized traffic.
module tb_regfile_mp;

  localparam int N  = 64;
  localparam int M  = 32;
  localparam int NR = 2;
  localparam int A  = 5;

  logic            Clk;
  logic            Rst;
  logic [NR*A-1:0] ReadAddr;
  logic [NR-1:0]   REn;
  logic [NR*N-1:0] Vout;
  logic [A-1:0]    WriteAddr;
  logic [N-1:0]    Vin;
  logic            WEn;
  logic            Clr;
  logic            Pwr_off;
  logic            Busy;

  regfile_mp #(.N(N), .M(M), .NR(NR), .ZERO_REG(1)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .ReadAddr  (ReadAddr),
    .REn       (REn),
    .Vout      (Vout),
    .WriteAddr (WriteAddr),
    .Vin       (Vin),
    .WEn       (WEn),
    .Clr       (Clr),
    .Pwr_off   (Pwr_off),
    .Busy      (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [NR*N-1:0] vout;
    logic            busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Behavioural model: mode 0 idle, 1 clearing, 2 powered off.
  logic [N-1:0]    mem [M];
  logic [NR*N-1:0] m_vout;
  logic            m_busy;
  int              mode;
  int              pos;

  task automatic model();
    logic [N-1:0] rv;
    int           a;
    bit           wacc;
    if (Rst) begin
      for (int i = 0; i < M; i++) mem[i] = '0;
      m_vout = '0;
      m_busy = 1'b0;
      mode   = 0;
      pos    = 0;
    end else if (Pwr_off) begin
      m_vout = '0;
      m_busy = 1'b1;
      mode   = 2;
    end else if (mode == 2) begin
      m_vout = '0;
      m_busy = 1'b1;
      mode   = 1;
      pos    = 0;
    end else begin
      wacc = (mode == 0) && WEn && (WriteAddr != 0);
      for (int k = 0; k < NR; k++) begin
        if (REn[k]) begin
          a = int'(ReadAddr[k*A +: A]);
          if (a == 0)                             rv = '0;
          else if (wacc && int'(WriteAddr) == a)  rv = Vin;
          else if (mode == 1 && a == pos)         rv = '0;
          else                                    rv = mem[a];
          m_vout[k*N +: N] = rv;
        end
      end
      if (mode == 0) begin
        if (wacc) mem[WriteAddr] = Vin;
        if (Clr) begin
          mode   = 1;
          pos    = 0;
          m_busy = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        mem[pos] = '0;
        pos      = pos + 1;
        if (pos == M) begin
          mode   = 0;
          m_busy = 1'b0;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
  endtask

  // Inputs are applied at the falling edge; one expectation per rising edge.
  task automatic step();
    exp_t e;
    model();
    e.vout = m_vout;
    e.busy = m_busy;
    q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic quiet();
    Rst = 0; WEn = 0; Clr = 0; Pwr_off = 0; REn = '0;
  endtask

  task automatic wr(input int a, input logic [N-1:0] d);
    quiet();
    WEn = 1; WriteAddr = A'(a); Vin = d;
    step();
  endtask

  task automatic rd(input int a0, input int a1);
    quiet();
    REn = 2'b11;
    ReadAddr = {A'(a1), A'(a0)};
    step();
  endtask

  task automatic chk_len(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Monitor: compare every registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        for (int k = 0; k < NR; k++) begin
          checks++;
          if (Vout[k*N +: N] !== e.vout[k*N +: N]) begin
            errors++;
            $display("FAIL vout%0d cycle %0d: got %h want %h", k, cyc,
                     Vout[k*N +: N], e.vout[k*N +: N]);
          end
        end
        checks++;
        if (Busy !== e.busy) begin
          errors++;
          $display("FAIL busy cycle %0d: got %b want %b", cyc, Busy, e.busy);
        end
      end
    end
  end

  initial begin
    int n;
    quiet();
    ReadAddr = '0; WriteAddr = '0; Vin = '0;
    Rst = 1;
    step();
    step();

    // basic write/read, bypass, zero register, hold
    wr(5, 64'hDEAD_BEEF);
    rd(5, 5);
    quiet();
    WEn = 1; WriteAddr = 7; Vin = 64'h1234;
    REn = 2'b01; ReadAddr = {A'(0), A'(7)};
    step();
    wr(0, 64'hFFFF);
    rd(0, 0);
    rd(5, 7);
    quiet();
    REn = 2'b10; ReadAddr = {A'(0), A'(9)};
    step();
    step();

    // fill then clear; writes during Busy must be dropped
    for (int i = 0; i < M; i++) wr(i, 64'(i + 1));
    quiet(); Clr = 1;
    step();
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      quiet();
      WEn = 1; WriteAddr = A'($urandom); Vin = 64'hBAD;
      REn = 2'($urandom); ReadAddr = NR*A'($urandom);
      step();
    end
    chk_len("clr_busy_len", n, M);
    for (int i = 0; i < M; i += 2) rd(i, i + 1);

    // power-off in the middle of a clear (ClrPtr = 10)
    for (int i = 0; i < M; i++) wr(i, {$urandom, $urandom});
    quiet(); Clr = 1;
    step();
    for (int i = 0; i < 10; i++) begin quiet(); step(); end
    quiet(); Pwr_off = 1; REn = 2'b11;
    step();
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      quiet();
      Pwr_off = (n < 5);
      REn = 2'b11; ReadAddr = NR*A'($urandom);
      step();
    end
    chk_len("pwr_busy_len", n, 5 + M);
    for (int i = 0; i < M; i += 2) rd(i, i + 1);

    // reset in the middle of a clear (ClrPtr = 3)
    for (int i = 0; i < M; i++) wr(i, {$urandom, $urandom});
    rd(4, 6);
    quiet(); Clr = 1;
    step();
    for (int i = 0; i < 3; i++) begin quiet(); step(); end
    quiet(); Rst = 1;
    step();
    wr(9, 64'h55AA);
    rd(9, 20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Rst       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) Pwr_off = ~Pwr_off;
      else if (Pwr_off && $urandom_range(0, 3) == 0) Pwr_off = 0;
      Clr       = ($urandom_range(0, 59) == 0);
      WEn       = $urandom_range(0, 1) == 1;
      WriteAddr = A'($urandom);
      Vin       = {$urandom, $urandom};
      REn       = 2'($urandom);
      ReadAddr  = NR*A'($urandom);
      step();
    end
    quiet();
    step();

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge Clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain: got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file. It is the next generation of the core's single-port register file: one write port, NR independent registered read ports, optional hardwired-zero register 0, write-first bypass, and a sequential clear engine driven by a software clear request or by power-down recovery. It sits between decode (read addresses) and writeback (write port) in the integer datapath.

## Interface
- N, 64, register width in bits
- M, 32, number of registers (power of two, ≥4)
- NR, 2, number of read ports (≥1)
- ZERO_REG, 1, 1 = register 0 always reads zero and ignores writes
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- ReadAddr  in  NR*$clog2(M)  packed read addresses; port k at bits [k*A +: A], A=$clog2(M)
- REn  in  NR  per-port read enable
- Vout  out  NR*N  packed registered read data; port k at bits [k*N +: N]
- WriteAddr  in  $clog2(M)  write address
- Vin  in  N  write data
- WEn  in  1  write enable
- Clr  in  1  single-cycle request to start a sequential clear of all registers
- Pwr_off  in  1  synchronous power-down level; contents are treated as lost while high
- Busy  out  1  high while in OFF or CLEAR; writes and Clr are ignored

## Operation
- States: IDLE, CLEAR, OFF. Control state is a 2-bit register; clear pointer ClrPtr is $clog2(M) bits.
- Rst (highest priority): all M registers set to 0, all Vout set to 0, state IDLE, ClrPtr 0, Busy 0.
- Pwr_off (second priority) from any state: next state OFF. While in OFF: writes ignored, Vout forced to 0 on every edge, Clr ignored.
- OFF with Pwr_off low: next state CLEAR, ClrPtr set to 0.
- IDLE with Clr high: next state CLEAR, ClrPtr set to 0. The write presented in the same cycle is performed.
- CLEAR: each cycle writes 0 to RegFile[ClrPtr] and increments ClrPtr. When ClrPtr == M-1, that register is cleared and the next state is IDLE. Duration is exactly M cycles. WEn and Clr are ignored.
- Write in IDLE: if WEn, RegFile[WriteAddr] <= Vin, except when ZERO_REG=1 and WriteAddr==0.
- Read port k in IDLE or CLEAR:
  - If REn[k] is high, Vout_k <= value of register ReadAddr_k.
  - If REn[k] is low, Vout_k holds its previous value. There is no tri-state.
- Read value rules, in priority order:
  - ZERO_REG=1 and address 0 → 0.
  - In IDLE, a write accepted in the same cycle to the same address → Vin (write-first bypass).
  - In CLEAR, an address equal to ClrPtr → 0.
  - Otherwise the stored value.
- A read in CLEAR of a register not yet cleared returns its stale content. Software must wait for Busy low.
- All read ports are independent. Any number of ports may address the same register.

## Timing
- Read latency 1 cycle: address and REn sampled at edge t, data valid on Vout after edge t.
- Write visible to a same-cycle read via bypass. Visible to any later read from the following cycle.
- Busy is registered and reflects the state after the edge: it rises the cycle after Clr or Pwr_off is sampled. It falls after the edge that clears register M-1.
- Clr pulse → Busy high for exactly M cycles.
- Pwr_off high for P cycles → Busy high for P + M cycles.
- Reset values: Vout all 0, Busy 0, array all 0.
- Rst during CLEAR or OFF aborts immediately to IDLE with the array zeroed.
- Pwr_off asserted mid-CLEAR restarts the full clear after Pwr_off falls.
- Clr asserted while Busy is ignored; it is not queued.

## Structure
- Package regfile_pkg holds:
  - the state enum (IDLE, CLEAR, OFF) as localparam encodings 2'd0, 2'd1, 2'd2;
  - a function to compute the address width.
- One sub-module, regfile_rd_port. It is instantiated NR times via generate and contains the ZERO_REG / bypass / clear-pointer mux and the Vout_k register with hold-on-!REn.
- Array, write logic and FSM stay in the top module.

## Test plan
- Reset then IDLE with N=64, M=32, NR=2:
  - write R5=0xDEAD_BEEF; next cycle read port0 R5, port1 R5 → both Vout = 0xDEAD_BEEF one cycle later.
- Bypass and zero register:
  - same cycle WEn with WriteAddr=7, Vin=0x1234 and port0 reading R7 → Vout0=0x1234 next cycle.
  - ZERO_REG=1: write R0=0xFFFF, then read R0 → 0.
- Hold:
  - read R5 (0xDEAD_BEEF), then drop REn[0] and change ReadAddr → Vout0 stays 0xDEAD_BEEF.
- Clr sequence:
  - fill all 32 registers with their index+1, pulse Clr → Busy high for exactly 32 cycles.
  - WEn during Busy has no effect; all reads afterwards return 0.
- Power-off:
  - Pwr_off high 5 cycles mid-CLEAR (ClrPtr=10) → Vout=0 throughout OFF; Busy stays high for 5+32 cycles; all registers read 0 afterwards.
- Rst at ClrPtr=3 → next cycle Busy=0, state IDLE, all Vout 0; a write is accepted the cycle after.
